// File: rtl/hash_func.sv
// Sequential dual-hash generator: hash1 = key mod HASH1_MOD, hash2 = (key div HASH1_MOD) mod HASH2_MOD.
// Two back-to-back 32-cycle bit-serial restoring divisions; one result every 65 cycles at best.
module hash_func #(
  parameter int unsigned HASH1_MOD = 11,
  parameter int unsigned HASH2_MOD = 23
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] key,
  output logic        busy,
  output logic        valid,
  output logic [31:0] hash1,
  output logic [31:0] hash2
);

  localparam int unsigned KW  = 32;
  localparam int unsigned CW  = 5;
  localparam int unsigned R1W = $clog2(HASH1_MOD) + 1;
  localparam int unsigned R2W = $clog2(HASH2_MOD) + 1;

  localparam logic [R1W:0]   D1   = (R1W + 1)'(HASH1_MOD);
  localparam logic [R2W:0]   D2   = (R2W + 1)'(HASH2_MOD);
  localparam logic [CW-1:0]  LAST = CW'(KW - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PHASE_A = 2'd1,
    PHASE_B = 2'd2
  } state_t;

  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [KW-1:0]   sh, sh_n;
  logic [R1W-1:0]  rem_a, rem_a_n;
  logic [R2W-1:0]  rem_b, rem_b_n;
  logic            busy_n, valid_n;
  logic [31:0]     hash1_n, hash2_n;

  logic [R1W:0]    trial_a;
  logic [R2W:0]    trial_b;
  logic            ge_a, ge_b;
  logic [R1W-1:0]  step_a;
  logic [R2W-1:0]  step_b;

  // One restoring-division step per phase; sh holds the dividend and collects quotient bits.
  always_comb begin
    trial_a = {rem_a, sh[KW-1]};
    ge_a    = (trial_a >= D1);
    step_a  = R1W'(ge_a ? (trial_a - D1) : trial_a);
    trial_b = {rem_b, sh[KW-1]};
    ge_b    = (trial_b >= D2);
    step_b  = R2W'(ge_b ? (trial_b - D2) : trial_b);
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    sh_n    = sh;
    rem_a_n = rem_a;
    rem_b_n = rem_b;
    busy_n  = busy;
    valid_n = 1'b0;
    hash1_n = hash1;
    hash2_n = hash2;
    case (state)
      IDLE: begin
        if (start) begin
          sh_n    = key;
          rem_a_n = '0;
          rem_b_n = '0;
          cnt_n   = '0;
          busy_n  = 1'b1;
          state_n = PHASE_A;
        end
      end
      PHASE_A: begin
        rem_a_n = step_a;
        sh_n    = {sh[KW-2:0], ge_a};
        cnt_n   = cnt + CW'(1);
        if (cnt == LAST) state_n = PHASE_B;
      end
      PHASE_B: begin
        rem_b_n = step_b;
        sh_n    = {sh[KW-2:0], ge_b};
        cnt_n   = cnt + CW'(1);
        if (cnt == LAST) begin
          state_n = IDLE;
          busy_n  = 1'b0;
          valid_n = 1'b1;
          hash1_n = 32'(rem_a);
          hash2_n = 32'(step_b);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      sh    <= '0;
      rem_a <= '0;
      rem_b <= '0;
      busy  <= 1'b0;
      valid <= 1'b0;
      hash1 <= '0;
      hash2 <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      sh    <= sh_n;
      rem_a <= rem_a_n;
      rem_b <= rem_b_n;
      busy  <= busy_n;
      valid <= valid_n;
      hash1 <= hash1_n;
      hash2 <= hash2_n;
    end
  end

endmodule

// File: tb/tb_hash_func.sv
// Self-checking bench for hash_func: reference model feeds a scoreboard at accept edges,
// a negedge monitor checks busy/valid/hash outputs against it every cycle.
module tb_hash_func;

  localparam int unsigned H1 = 11;
  localparam int unsigned H2 = 23;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] key;
  logic        busy;
  logic        valid;
  logic [31:0] hash1;
  logic [31:0] hash2;

  hash_func #(.HASH1_MOD(H1), .HASH2_MOD(H2)) dut (
    .clock(clock),
    .reset(reset),
    .start(start),
    .key  (key),
    .busy (busy),
    .valid(valid),
    .hash1(hash1),
    .hash2(hash2)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] k;
    logic [31:0] h1;
    logic [31:0] h2;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad   = 0;
  int          left  = 0;
  bit          exp_valid = 1'b0;
  logic [31:0] last_h1 = '0;
  logic [31:0] last_h2 = '0;

  // Reference model: tracks accept edges and remaining latency independently of the DUT.
  always @(posedge clock or posedge reset) begin
    exp_t e;
    if (reset) begin
      left      = 0;
      exp_valid = 1'b0;
      sb.delete();
      last_h1   = '0;
      last_h2   = '0;
    end else begin
      exp_valid = 1'b0;
      if (left == 0) begin
        if (start === 1'b1) begin
          e.k  = key;
          e.h1 = key % 32'(H1);
          e.h2 = (key / 32'(H1)) % 32'(H2);
          sb.push_back(e);
          left = 64;
        end
      end else begin
        left = left - 1;
        if (left == 0) exp_valid = 1'b1;
      end
    end
  end

  // Monitor: every cycle, away from the active edge.
  always @(negedge clock) begin
    exp_t e;
    total++;
    if (valid !== exp_valid) begin
      bad++;
      $display("FAIL valid t=%0t got=%b want=%b", $time, valid, exp_valid);
    end
    total++;
    if (busy !== (left != 0)) begin
      bad++;
      $display("FAIL busy t=%0t got=%b want=%b", $time, busy, (left != 0));
    end
    if (exp_valid) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL scoreboard_empty t=%0t got=empty want=entry", $time);
      end else begin
        e = sb.pop_front();
        last_h1 = e.h1;
        last_h2 = e.h2;
      end
    end
    total++;
    if (hash1 !== last_h1) begin
      bad++;
      $display("FAIL hash1 t=%0t got=%0d want=%0d", $time, hash1, last_h1);
    end
    total++;
    if (hash2 !== last_h2) begin
      bad++;
      $display("FAIL hash2 t=%0t got=%0d want=%0d", $time, hash2, last_h2);
    end
  end

  // Wait for all pending results, scrambling key meanwhile; bounded.
  task automatic wait_done();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clock);
      #1 key = $urandom;
      n++;
    end
    @(negedge clock);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL timeout got=%0d_pending want=0", sb.size());
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b1;
    key   = 32'd25;
    repeat (3) @(posedge clock);
    #1;
    total++; if (busy  !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", busy); end
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b want=0", valid); end
    total++; if (hash1 !== 32'd0) begin bad++; $display("FAIL rst_hash1 got=%0d want=0", hash1); end
    total++; if (hash2 !== 32'd0) begin bad++; $display("FAIL rst_hash2 got=%0d want=0", hash2); end
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
    start = 1'b0;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL rst_first_accept got=%b want=1", busy); end
    wait_done();
    total++; if (hash1 !== 32'd3) begin bad++; $display("FAIL rst_key25_h1 got=%0d want=3", hash1); end
    total++; if (hash2 !== 32'd2) begin bad++; $display("FAIL rst_key25_h2 got=%0d want=2", hash2); end
  endtask

  task automatic test_key(input logic [31:0] k, input logic [31:0] e1, input logic [31:0] e2);
    @(posedge clock);
    #1 start = 1'b1;
    key = k;
    @(posedge clock);
    #1 start = 1'b0;
    key = $urandom;
    wait_done();
    total++;
    if (hash1 !== e1) begin bad++; $display("FAIL key_h1 key=%0h got=%0d want=%0d", k, hash1, e1); end
    total++;
    if (hash2 !== e2) begin bad++; $display("FAIL key_h2 key=%0h got=%0d want=%0d", k, hash2, e2); end
  endtask

  task automatic test_reset_mid();
    @(posedge clock);
    #1 start = 1'b1;
    key = 32'd1000;
    @(posedge clock);
    #1 start = 1'b0;
    repeat (20) @(posedge clock);
    #1 reset = 1'b1;
    #1;
    total++; if (busy  !== 1'b0) begin bad++; $display("FAIL mid_busy got=%b want=0", busy); end
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL mid_valid got=%b want=0", valid); end
    total++; if (hash1 !== 32'd0) begin bad++; $display("FAIL mid_hash1 got=%0d want=0", hash1); end
    total++; if (hash2 !== 32'd0) begin bad++; $display("FAIL mid_hash2 got=%0d want=0", hash2); end
    @(negedge clock);
    reset = 1'b0;
    repeat (80) @(posedge clock);
  endtask

  task automatic test_back_to_back();
    time prev = 0;
    bit  seen = 1'b0;
    int  pulses = 0;
    @(posedge clock);
    #1 start = 1'b1;
    key = $urandom;
    for (int i = 0; i < 196; i++) begin
      @(negedge clock);
      if (valid === 1'b1) begin
        pulses++;
        if (seen) begin
          total++;
          if ($time - prev != 650) begin
            bad++;
            $display("FAIL b2b_gap got=%0t want=650", $time - prev);
          end
        end
        prev = $time;
        seen = 1'b1;
      end
      @(posedge clock);
      #1 key = $urandom;
    end
    start = 1'b0;
    total++;
    if (pulses != 3) begin bad++; $display("FAIL b2b_pulses got=%0d want=3", pulses); end
    wait_done();
  endtask

  initial begin
    start = 1'b0;
    key   = '0;
    reset = 1'b1;
    test_reset();
    test_key(32'd0,          32'd0, 32'd0);
    test_key(32'd25,         32'd3, 32'd2);
    test_key(32'd100,        32'd1, 32'd9);
    test_key(32'd253,        32'd0, 32'd0);
    test_key(32'd264,        32'd0, 32'd1);
    test_key(32'hFFFF_FFFF,  32'd3, 32'd7);
    test_reset_mid();
    test_back_to_back();
    for (int i = 0; i < 3; i++) begin
      logic [31:0] r;
      r = $urandom;
      test_key(r, r % 32'(H1), (r / 32'(H1)) % 32'(H2));
    end
    repeat (5) @(posedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
